// File: rtl/div_seq_n_if.sv
// Request/result bundle for the sequential divider: operands in, registered result and status out.
interface div_seq_n_if #(
    parameter int W = 8
);
    logic         start;
    logic         signed_mode;
    logic [W-1:0] D;
    logic [W-1:0] divider;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         busy;
    logic         valid;
    logic         div_zero;
    logic         ovf;

    modport master (
        output start, signed_mode, D, divider,
        input  q, r, busy, valid, div_zero, ovf
    );

    modport slave (
        input  start, signed_mode, D, divider,
        output q, r, busy, valid, div_zero, ovf
    );
endinterface

// File: rtl/div_seq_n.sv
// Restoring shift-subtract divider, one quotient bit per clock, with signed/unsigned
// operands, divide-by-zero and signed-overflow reporting.
//   state | meaning
//   IDLE  | waiting for start; last result held on q/r
//   RUN   | W shift-subtract iterations on operand magnitudes
//   DONE  | one cycle: sign correction / special cases loaded into q/r
module div_seq_n #(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    div_seq_n_if.slave  bus
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_next;

    logic [CW-1:0]  r_cnt;
    logic [W:0]     r_rem;
    logic [W-1:0]   r_quo;
    logic [W-1:0]   r_dvs;
    logic [W-1:0]   r_d_raw;
    logic [W-1:0]   r_q;
    logic [W-1:0]   r_r;
    logic           r_neg_q;
    logic           r_neg_r;
    logic           r_zero;
    logic           r_ovf_case;
    logic           r_valid;
    logic           r_div_zero;
    logic           r_ovf;

    logic           w_d_neg;
    logic           w_v_neg;
    logic [W-1:0]   w_abs_d;
    logic [W-1:0]   w_abs_v;
    logic           w_ovf_in;
    logic           w_tc;
    logic [W:0]     w_shift;
    logic [W:0]     w_sub;
    logic           w_fits;

    assign w_d_neg  = bus.signed_mode & bus.D[W-1];
    assign w_v_neg  = bus.signed_mode & bus.divider[W-1];
    assign w_abs_d  = w_d_neg ? -bus.D : bus.D;
    assign w_abs_v  = w_v_neg ? -bus.divider : bus.divider;
    assign w_ovf_in = bus.signed_mode && (bus.D == {1'b1, {(W-1){1'b0}}}) && (bus.divider == '1);
    assign w_tc     = (r_cnt == CW'(1));

    // Partial remainder shifted left with the next dividend bit; the trial compare uses the
    // full W+1 bit remainder so nothing is silently dropped.
    assign w_shift  = {r_rem[W-1:0], r_quo[W-1]};
    assign w_fits   = ({r_rem, r_quo[W-1]} >= {2'b00, r_dvs});
    assign w_sub    = w_shift - {1'b0, r_dvs};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (bus.start) w_next = (bus.divider == '0) ? DONE : RUN;
            RUN:  if (w_tc) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_d_raw    <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_zero     <= 1'b0;
            r_ovf_case <= 1'b0;
            r_valid    <= 1'b0;
            r_div_zero <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_d_raw    <= bus.D;
                        r_quo      <= w_abs_d;
                        r_dvs      <= w_abs_v;
                        r_rem      <= '0;
                        r_cnt      <= CW'(W);
                        r_neg_q    <= w_d_neg ^ w_v_neg;
                        r_neg_r    <= w_d_neg;
                        r_zero     <= (bus.divider == '0);
                        r_ovf_case <= w_ovf_in;
                        r_valid    <= 1'b0;
                        r_div_zero <= 1'b0;
                        r_ovf      <= 1'b0;
                    end
                end
                RUN: begin
                    r_rem <= w_fits ? w_sub : w_shift;
                    r_quo <= {r_quo[W-2:0], w_fits};
                    r_cnt <= r_cnt - CW'(1);
                end
                DONE: begin
                    r_valid <= 1'b1;
                    if (r_zero) begin
                        r_q        <= '1;
                        r_r        <= r_d_raw;
                        r_div_zero <= 1'b1;
                    end else if (r_ovf_case) begin
                        r_q   <= r_d_raw;
                        r_r   <= '0;
                        r_ovf <= 1'b1;
                    end else begin
                        r_q <= r_neg_q ? -r_quo : r_quo;
                        r_r <= r_neg_r ? -r_rem[W-1:0] : r_rem[W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.q        = r_q;
    assign bus.r        = r_r;
    assign bus.busy     = (r_state != IDLE);
    assign bus.valid    = r_valid;
    assign bus.div_zero = r_div_zero;
    assign bus.ovf      = r_ovf;
endmodule

// File: doc/div_seq_n.md
DIV_SEQ_N -- requirements
Module: div_seq_n

Interface
REQ-001 The block SHALL have parameter W, default 8: operand, quotient and remainder width, legal range 4..32.
REQ-002 Port `clk`, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port `start`, input, 1 bit: request a division; sampled only when `busy`=0.
REQ-005 Port `signed_mode`, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with `start`.
REQ-006 Port `D`, input, W bits: dividend; sampled with `start`.
REQ-007 Port `divider`, input, W bits: divisor; sampled with `start`.
REQ-008 Port `q`, output, W bits: quotient (registered).
REQ-009 Port `r`, output, W bits: remainder (registered).
REQ-010 Port `busy`, output, 1 bit: division in progress.
REQ-011 Port `valid`, output, 1 bit: `q`/`r` hold a completed result.
REQ-012 Port `div_zero`, output, 1 bit: the last result came from a zero divisor.
REQ-013 Port `ovf`, output, 1 bit: the last result was signed overflow (most-negative / -1).

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; DONE is a 1-cycle internal state that loads the result and returns to IDLE.
REQ-015 Accept: at an edge with `start`=1 and `busy`=0, the block SHALL latch `D`, `divider` and `signed_mode`, clear `valid`, `div_zero` and `ovf`, set `busy`=1 and enter RUN.
REQ-016 While `busy`=1, `start` SHALL be ignored and the latched operands SHALL be unaffected by input changes.
REQ-017 Unsigned divide: restoring shift-subtract, one quotient bit per cycle, MSB first.
REQ-018 Iteration width: the partial remainder SHALL be W+1 bits wide and the iteration count SHALL be W (counter ceil(log2(W+1)) bits).
REQ-019 Signed divide: divide |D| by |divider| as unsigned.
  - Quotient negated when the operand signs differ.
  - Remainder takes the sign of D.
  - Result truncates toward zero.
REQ-020 Latency: accept at edge E0; W iteration edges E1..EW; final correction and load at edge E(W+1), where `q`/`r` update, `valid`=1 and `busy`=0.
REQ-021 Divisor zero (detected at E0): skip RUN; at E1 the block SHALL set `q`=all ones, `r`=D (raw bits), `div_zero`=1, `valid`=1 and `busy`=0.
REQ-022 Signed overflow (signed_mode=1, D=most negative, divider=-1): the normal W+1 latency SHALL apply, with `q`=D, `r`=0 and `ovf`=1.
REQ-023 While `busy`=1, `q`/`r` SHALL hold the previous result; `valid` stays 0 until completion.
REQ-024 `valid`, `q`, `r`, `div_zero` and `ovf` SHALL hold until the next accepted `start` or `rst`.
REQ-025 Back-to-back: `start`=1 on the same cycle that `valid` first rises SHALL be accepted, since `busy`=0 at that edge.
REQ-026 For every accepted unsigned case, the result SHALL satisfy D = q*divider + r with r < divider.

Reset
REQ-027 When `rst`=1 at an edge, all of the following SHALL hold: FSM=IDLE; `busy`, `valid`, `div_zero`, `ovf`=0; `q`, `r`=0; internal counters cleared.
REQ-028 `rst` SHALL take priority over `start`, and a reset mid-division SHALL abandon the operation with no result produced.

Verification
REQ-029 With W=8, unsigned D=200, divider=7 -> after 9 clocks: `valid`=1, q=28, r=4, div_zero=0.
REQ-030 With W=8, divider=0, D=200 -> after 1 clock: q=0xFF, r=0xC8, div_zero=1, valid=1.
REQ-031 With W=8 signed: D=-7 (0xF9), divider=2 -> q=0xFD (-3), r=0xFF (-1).
REQ-032 With W=8 signed: D=0x80, divider=0xFF -> q=0x80, r=0x00, ovf=1 after 9 clocks.
REQ-033 With W=8: 100/3 accepted; at cycle 3 apply `start` with 50/5 -> that start is ignored, result q=33, r=1; then `start` on the `valid` cycle with 50/5 -> q=10, r=0 after 9 more clocks.
REQ-034 With W=8: assert `rst` at cycle 4 of 255/1 -> next cycle busy=0, valid=0, q=0, r=0; a fresh 9/2 then gives q=4, r=1.
REQ-035 Regression: randomized unsigned and signed operands for W=8, 16 and 32, checked against a reference model, with REQ-026 checked on every unsigned result.
